// File: rtl/dequeueing_rx.sv
// Collects six UART RX bytes into a frame and presents it with a one-cycle strobe.
// Partial frames are dropped on inter-byte timeout or when the block is disabled.
module dequeueing_rx #(
  parameter int TIMEOUT = 104168,
  parameter int CNT_W   = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [7:0] data3,
  output logic [7:0] data4,
  output logic [7:0] data5,
  output logic [7:0] data6,
  output logic       frame_valid,
  output logic       err_timeout,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_tcnt;
  logic [5:0][7:0]  r_shadow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_tcnt      <= '0;
      r_shadow    <= '0;
      data1       <= '0;
      data2       <= '0;
      data3       <= '0;
      data4       <= '0;
      data5       <= '0;
      data6       <= '0;
      frame_valid <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else if (!en) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_tcnt      <= '0;
      frame_valid <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rx_done) begin
            r_shadow[0] <= rx_data;
            r_idx       <= 3'd1;
            r_tcnt      <= '0;
            r_state     <= COLLECT;
            busy        <= 1'b1;
          end
        end
        COLLECT: begin
          // An arriving byte beats a timeout expiring on the same edge.
          if (rx_done) begin
            r_shadow[r_idx] <= rx_data;
            r_tcnt          <= '0;
            if (r_idx == 3'd5) r_state <= DONE;
            else               r_idx   <= r_idx + 3'd1;
          end else if (r_tcnt == CNT_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            r_idx       <= '0;
            r_tcnt      <= '0;
            r_state     <= IDLE;
            busy        <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + CNT_W'(1);
          end
        end
        DONE: begin
          data1       <= r_shadow[0];
          data2       <= r_shadow[1];
          data3       <= r_shadow[2];
          data4       <= r_shadow[3];
          data5       <= r_shadow[4];
          data6       <= r_shadow[5];
          frame_valid <= 1'b1;
          r_tcnt      <= '0;
          // A byte on this cycle opens the next frame; the copy above uses old shadow.
          if (rx_done) begin
            r_shadow[0] <= rx_data;
            r_idx       <= 3'd1;
            r_state     <= COLLECT;
          end else begin
            r_idx   <= '0;
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
          r_tcnt  <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dequeueing_rx.sv
// Directed and randomized bench for dequeueing_rx against a byte-queue reference model.
module tb_dequeueing_rx;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n, en, rx_done;
  logic [7:0] rx_data;
  logic [7:0] data1, data2, data3, data4, data5, data6;
  logic       frame_valid, err_timeout, busy;

  int checks = 0;
  int failures = 0;

  dequeueing_rx #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rx_data(rx_data), .rx_done(rx_done),
    .data1(data1), .data2(data2), .data3(data3), .data4(data4), .data5(data5),
    .data6(data6), .frame_valid(frame_valid), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the frame in progress, idle cycles since last byte,
  // and a completed frame waiting to be published on the next edge.
  logic [7:0]  q[$];
  int          gap;
  logic        pend;
  logic [47:0] pend_frame;
  logic [47:0] e_data;
  logic        e_fv, e_err, e_busy;
  int          fv_cnt, err_cnt;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic e, input logic r, input logic d, input logic [7:0] b);
    if (!r) begin
      q.delete(); gap = 0; pend = 1'b0; pend_frame = '0;
      e_data = '0; e_fv = 1'b0; e_err = 1'b0; e_busy = 1'b0;
    end else if (!e) begin
      q.delete(); gap = 0; pend = 1'b0;
      e_fv = 1'b0; e_err = 1'b0; e_busy = 1'b0;
    end else begin
      e_fv = 1'b0; e_err = 1'b0;
      if (pend) begin
        e_data = pend_frame; e_fv = 1'b1; pend = 1'b0;
        if (d) begin q.push_back(b); gap = 0; e_busy = 1'b1; end
        else e_busy = 1'b0;
      end else if (d) begin
        q.push_back(b); gap = 0; e_busy = 1'b1;
        if (q.size() == 6) begin
          for (int i = 0; i < 6; i++) pend_frame[47-8*i -: 8] = q[i];
          q.delete(); pend = 1'b1;
        end
      end else if (q.size() > 0) begin
        gap++;
        if (gap == TO) begin
          e_err = 1'b1; q.delete(); gap = 0; e_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input logic e, input logic r, input logic d, input logic [7:0] b);
    en = e; rst_n = r; rx_done = d; rx_data = b;
    @(posedge clk);
    model(e, r, d, b);
    #1;
    if (frame_valid === 1'b1) fv_cnt++;
    if (err_timeout === 1'b1) err_cnt++;
    chk("frame_valid", 48'(frame_valid), 48'(e_fv));
    chk("err_timeout", 48'(err_timeout), 48'(e_err));
    chk("busy", 48'(busy), 48'(e_busy));
    chk("data", {data1, data2, data3, data4, data5, data6}, e_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b, input int spacing);
    step(1'b1, 1'b1, 1'b1, b);
    idle(spacing - 1);
  endtask

  initial begin
    logic [47:0] t1, ta;
    t1 = 48'h112233445566;
    ta = 48'hA1A2A3A4A5A6;
    gap = 0; pend = 1'b0; pend_frame = '0; e_data = '0;
    e_fv = 1'b0; e_err = 1'b0; e_busy = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'hFF);
    chk("reset_data", {data1, data2, data3, data4, data5, data6}, 48'h0);

    // 1: bytes spaced 10 cycles; pulse lands two edges after last byte
    fv_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 5; i++) send(t1[47-8*i -: 8], 10);
    step(1'b1, 1'b1, 1'b1, 8'h66);
    chk("t1_no_pulse_yet", 48'(frame_valid), 48'h0);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("t1_pulse", 48'(frame_valid), 48'h1);
    chk("t1_data", {data1, data2, data3, data4, data5, data6}, t1);
    idle(3);
    chk("t1_fv_count", 48'(fv_cnt), 48'd1);
    chk("t1_err_count", 48'(err_cnt), 48'd0);

    // 2: partial frame times out exactly 20 edges after the last byte
    fv_cnt = 0; err_cnt = 0;
    send(8'h01, 2); send(8'h02, 2);
    step(1'b1, 1'b1, 1'b1, 8'h03);
    idle(TO - 1);
    chk("t2_err_early", 48'(err_cnt), 48'd0);
    idle(1);
    chk("t2_err_pulse", 48'(err_timeout), 48'h1);
    idle(5);
    chk("t2_err_count", 48'(err_cnt), 48'd1);
    chk("t2_fv_count", 48'(fv_cnt), 48'd0);
    chk("t2_data_held", {data1, data2, data3, data4, data5, data6}, t1);
    chk("t2_busy", 48'(busy), 48'h0);
    for (int i = 0; i < 6; i++) send(ta[47-8*i -: 8], 2);
    chk("t2_frame_a", {data1, data2, data3, data4, data5, data6}, ta);

    // 3: enable drop mid-frame, then reset mid-frame
    fv_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 2);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t3_busy_off", 48'(busy), 48'h0);
    for (int i = 0; i < 6; i++) send(8'hD0 + 8'(i), 2);
    chk("t3_clean_frame", {data1, data2, data3, data4, data5, data6}, 48'hD0D1D2D3D4D5);
    chk("t3_fv_count", 48'(fv_cnt), 48'd1);
    chk("t3_err_count", 48'(err_cnt), 48'd0);
    for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i), 2);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("t3_reset_outs", {data1, data2, data3, data4, data5, data6, 5'd0, frame_valid, err_timeout, busy}, 56'h0);

    // 4: byte arrives on the tcnt==TO-1 cycle
    err_cnt = 0;
    step(1'b1, 1'b1, 1'b1, 8'h41);
    idle(TO - 1);
    step(1'b1, 1'b1, 1'b1, 8'h42);
    chk("t4_no_err", 48'(err_cnt), 48'd0);
    for (int i = 3; i <= 6; i++) send(8'h40 + 8'(i), 1);
    idle(1);
    chk("t4_frame", {data1, data2, data3, data4, data5, data6}, 48'h414243444546);

    // 5: back-to-back frames, byte 0 of frame 2 in the DONE cycle
    fv_cnt = 0;
    for (int i = 0; i < 12; i++) send(8'h50 + 8'(i), 1);
    chk("t5_frame1", {data1, data2, data3, data4, data5, data6}, 48'h505152535455);
    idle(1);
    chk("t5_frame2", {data1, data2, data3, data4, data5, data6}, 48'h565758595A5B);
    chk("t5_fv_count", 48'(fv_cnt), 48'd2);

    // 6: bytes while disabled are ignored
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 8'hEE);
    chk("t6_hold", {data1, data2, data3, data4, data5, data6}, 48'h565758595A5B);
    chk("t6_busy", 48'(busy), 48'h0);

    // Randomized traffic with occasional long gaps and enable drops
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 60) == 0) idle(TO + $urandom_range(0, 3));
      else if ($urandom_range(0, 50) == 0) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
      else if ($urandom_range(0, 400) == 0) step(1'b1, 1'b0, 1'b0, 8'h00);
      else step(1'b1, 1'b1, 1'($urandom_range(0, 99) < 35), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
